// File: rtl/gfx_pkg.sv
// Shared graphics definitions for the framebuffer write path.
// Holds screen geometry, the pixel address type and the buffered pixel entry
// layout, plus the drain FSM state encoding used by pixel_write_buffer.
package gfx_pkg;

  localparam int SCREEN_W     = 640;
  localparam int SCREEN_H     = 480;
  localparam int PIX_ADDR_W   = 19;
  localparam int PIX_COLOR_W  = 8;
  localparam int MAX_PIX_ADDR = SCREEN_W * SCREEN_H - 1;

  typedef logic [PIX_ADDR_W-1:0]  pix_addr_t;
  typedef logic [PIX_COLOR_W-1:0] pix_color_t;

  typedef struct packed {
    pix_addr_t  addr;
    pix_color_t color;
  } pix_entry_t;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_WRITE = 1'b1
  } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO, WIDTH bits x DEPTH entries (DEPTH a power of two).
// Ports: push/wdata write the tail, pop advances the head, rdata shows the head
// combinationally; full/empty/count report occupancy. Push when full and pop
// when empty are ignored.
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  assign full   = (r_count == CW'(DEPTH));
  assign empty  = (r_count == '0);
  assign count  = r_count;
  assign rdata  = r_mem[r_rptr];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= wdata;
    end
  end

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH on their own.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/pixel_write_buffer.sv
// Buffers rasteriser pixel addresses and drains them to the framebuffer SRAM.
// Ports: address/addr_valid/color/prim_done from the rasteriser, stop back to it;
// mem_addr/mem_data/mem_wen with mem_ack to the SRAM; frame_done and sticky overflow.
module pixel_write_buffer
  import gfx_pkg::*;
#(
  parameter  int DEPTH       = 8,
  parameter  int ADDR_W      = PIX_ADDR_W,
  parameter  int COLOR_W     = PIX_COLOR_W,
  parameter  int STOP_THRESH = 6,
  parameter  int MAX_ADDR    = MAX_PIX_ADDR,
  localparam int CW          = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic [ADDR_W-1:0]  address,
  input  logic               addr_valid,
  input  logic [COLOR_W-1:0] color,
  input  logic               prim_done,
  output logic               stop,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [COLOR_W-1:0] mem_data,
  output logic               mem_wen,
  input  logic               mem_ack,
  output logic               frame_done,
  output logic               overflow
);

  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic [COLOR_W-1:0] color;
  } entry_t;

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);
  localparam logic [CW-1:0]     THR   = CW'(STOP_THRESH);

  drain_state_t       r_state;
  logic               r_mem_wen;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [COLOR_W-1:0] r_mem_data;
  logic               r_stop;
  logic               r_overflow;
  logic               r_frame_done;
  logic               r_done_pending;
  logic               r_last_valid;
  logic [ADDR_W-1:0]  r_last_addr;

  entry_t             w_wentry;
  entry_t             w_head;
  logic               w_full;
  logic               w_empty;
  logic [CW-1:0]      w_count;
  logic [CW-1:0]      w_next_count;
  logic               w_in_range;
  logic               w_dup;
  logic               w_cand;
  logic               w_push;
  logic               w_pop;
  logic               w_fire;

  // Push filter: clip off-screen addresses and collapse repeats of the last
  // accepted pixel (the rasteriser emits the same pixel on octant seams).
  assign w_in_range = (address <= MAX_A);
  assign w_dup      = r_last_valid && (address == r_last_addr);
  assign w_cand     = addr_valid && w_in_range && !w_dup;
  assign w_push     = w_cand && !w_full;

  // The writer is free when idle or when its current write is acknowledged.
  assign w_pop = !w_empty && ((r_state == S_IDLE) || mem_ack);

  // Completion waits for a fully drained pipe with nothing arriving this cycle.
  assign w_fire = r_done_pending && (r_state == S_IDLE) && w_empty && !w_push;

  assign w_wentry.addr  = address;
  assign w_wentry.color = color;

  always_comb begin
    w_next_count = w_count;
    if (w_push && !w_pop) begin
      w_next_count = w_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_next_count = w_count - 1'b1;
    end
  end

  sync_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .n_rst (n_rst),
    .push  (w_push),
    .pop   (w_pop),
    .wdata (w_wentry),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  // Drain FSM: the head is popped on the same edge it is loaded into the
  // SRAM request registers, so an acked write can be followed immediately.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_state    <= S_IDLE;
      r_mem_wen  <= 1'b0;
      r_mem_addr <= '0;
      r_mem_data <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!w_empty) begin
            r_mem_addr <= w_head.addr;
            r_mem_data <= w_head.color;
            r_mem_wen  <= 1'b1;
            r_state    <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (mem_ack) begin
            if (!w_empty) begin
              r_mem_addr <= w_head.addr;
              r_mem_data <= w_head.color;
            end else begin
              r_mem_wen <= 1'b0;
              r_state   <= S_IDLE;
            end
          end
        end
        default: begin
          r_mem_wen <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Stop looks at the post-update occupancy; the two spare entries above the
  // threshold absorb addresses the producer issues before it sees stop.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_stop       <= 1'b0;
      r_overflow   <= 1'b0;
      r_last_valid <= 1'b0;
      r_last_addr  <= '0;
    end else begin
      r_stop <= (w_next_count >= THR);
      if (w_cand && w_full) begin
        r_overflow <= 1'b1;
      end
      if (w_push) begin
        r_last_valid <= 1'b1;
        r_last_addr  <= address;
      end else if (w_fire) begin
        r_last_valid <= 1'b0;
      end
    end
  end

  // A prim_done landing on the firing cycle is merged into that pulse.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      r_frame_done   <= 1'b0;
      r_done_pending <= 1'b0;
    end else begin
      r_frame_done <= w_fire;
      if (w_fire) begin
        r_done_pending <= 1'b0;
      end else if (prim_done) begin
        r_done_pending <= 1'b1;
      end
    end
  end

  assign stop       = r_stop;
  assign mem_addr   = r_mem_addr;
  assign mem_data   = r_mem_data;
  assign mem_wen    = r_mem_wen;
  assign frame_done = r_frame_done;
  assign overflow   = r_overflow;

endmodule

// File: tb/tb_pixel_write_buffer.sv
// Self-checking bench for pixel_write_buffer: randomized stimulus against a
// queue-based reference model of the buffer, SRAM port and completion rules.
module tb_pixel_write_buffer;
  import gfx_pkg::*;

  localparam int DEPTH       = 8;
  localparam int STOP_THRESH = 6;
  localparam int MAX_ADDR    = 307199;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  pix_addr_t  address = '0;
  logic       addr_valid = 1'b0;
  pix_color_t color = '0;
  logic       prim_done = 1'b0;
  logic       stop;
  pix_addr_t  mem_addr;
  pix_color_t mem_data;
  logic       mem_wen;
  logic       mem_ack = 1'b0;
  logic       frame_done;
  logic       overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // reference model state
  pix_entry_t mq[$];
  pix_entry_t exp_wr[$];
  pix_entry_t dut_wr[$];
  pix_entry_t m_head;
  bit         m_busy, m_pend, m_lv, m_ovf, m_fd, m_stop;
  pix_addr_t  m_la;
  int         fd_count, fd_cyc, last_wr_cyc;

  pixel_write_buffer dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .address    (address),
    .addr_valid (addr_valid),
    .color      (color),
    .prim_done  (prim_done),
    .stop       (stop),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .mem_wen    (mem_wen),
    .mem_ack    (mem_ack),
    .frame_done (frame_done),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Record what the SRAM actually accepted, and each frame_done pulse.
  always @(negedge clk) begin
    if (n_rst && mem_wen && mem_ack) begin
      dut_wr.push_back({mem_addr, mem_data});
      last_wr_cyc = cyc;
    end
    if (n_rst && frame_done) begin
      fd_count++;
      fd_cyc = cyc;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic model_reset();
    mq.delete();
    exp_wr.delete();
    dut_wr.delete();
    m_busy = 0; m_pend = 0; m_lv = 0; m_ovf = 0; m_fd = 0; m_stop = 0;
    m_la = '0; m_head = '0;
    fd_count = 0; fd_cyc = -1; last_wr_cyc = -1;
  endtask

  // Drive one cycle of inputs, let the edge happen, advance the model.
  task automatic cycle(input bit v, input pix_addr_t a, input pix_color_t c,
                       input bit pd, input bit ack);
    int sz;
    bit cand, push, free;
    address = a; addr_valid = v; color = c; prim_done = pd; mem_ack = ack;
    @(posedge clk);
    sz   = mq.size();
    cand = v && (int'(a) <= MAX_ADDR) && !(m_lv && a == m_la);
    push = cand && (sz < DEPTH);
    free = !m_busy || ack;
    m_fd = m_pend && !m_busy && (sz == 0) && !push;
    if (m_fd) begin m_pend = 0; m_lv = 0; end
    else if (pd) m_pend = 1;
    if (free) begin
      if (sz > 0) begin m_head = mq.pop_front(); m_busy = 1; end
      else m_busy = 0;
    end
    if (push) begin
      mq.push_back({a, c});
      exp_wr.push_back({a, c});
      m_lv = 1; m_la = a;
    end
    if (cand && !push) m_ovf = 1;
    m_stop = (mq.size() >= STOP_THRESH);
    #1;
  endtask

  task automatic do_reset();
    addr_valid = 0; prim_done = 0; mem_ack = 0;
    n_rst = 0;
    repeat (2) @(posedge clk);
    #1;
    n_rst = 1;
    model_reset();
  endtask

  task automatic test_reset();
    n_rst = 0;
    #3;
    checks++;
    if ({stop, mem_wen, mem_addr, mem_data, frame_done, overflow} !== '0) begin
      errors++;
      $display("FAIL reset_hold: outputs=%h required 0",
               {stop, mem_wen, mem_addr, mem_data, frame_done, overflow});
    end
    do_reset();
    repeat (3) begin
      cycle(0, '0, '0, 0, 1);
      checks++;
      if ({stop, mem_wen, frame_done, overflow} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_idle: stop/wen/fd/ovf=%b required 0000",
                 {stop, mem_wen, frame_done, overflow});
      end
    end
  endtask

  task automatic test_basic();
    bit [6:0] trace;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 3) cycle(1, pix_addr_t'(i), pix_color_t'($urandom), 0, 1);
      else       cycle(0, '0, '0, 0, 1);
      trace[i] = mem_wen;
      checks++;
      if ({mem_wen, stop, frame_done, overflow} !== {m_busy, m_stop, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL basic_cycle %0d: wen/stop/fd/ovf=%b required %b", i,
                 {mem_wen, stop, frame_done, overflow}, {m_busy, m_stop, m_fd, m_ovf});
      end
    end
    checks++;
    if (trace !== 7'b0001110) begin
      errors++;
      $display("FAIL basic_wen_trace: got %b required 0001110 (bit0 = first cycle)", trace);
    end
    checks++;
    if (dut_wr.size() != 3) begin
      errors++;
      $display("FAIL basic_count: %0d writes required 3", dut_wr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (dut_wr[i] !== exp_wr[i] || int'(dut_wr[i].addr) != i) begin
          errors++;
          $display("FAIL basic_write %0d: got %h required addr %0d data %h", i,
                   dut_wr[i], i, exp_wr[i].color);
        end
      end
    end
  endtask

  task automatic test_dup_clip();
    pix_addr_t seq[4];
    seq[0] = 19'h12C00; seq[1] = 19'h12C00; seq[2] = 19'h12C01; seq[3] = 19'h4B000;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      if (i < 4) cycle(1, seq[i], pix_color_t'($urandom), 0, 1);
      else       cycle(0, '0, '0, 0, 1);
      checks++;
      if ({mem_wen, stop, frame_done, overflow} !== {m_busy, m_stop, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL dup_cycle %0d: wen/stop/fd/ovf=%b required %b", i,
                 {mem_wen, stop, frame_done, overflow}, {m_busy, m_stop, m_fd, m_ovf});
      end
    end
    checks++;
    if (dut_wr.size() != 2) begin
      errors++;
      $display("FAIL dup_count: %0d writes required 2", dut_wr.size());
    end else begin
      checks++;
      if (dut_wr[0].addr !== 19'h12C00 || dut_wr[1].addr !== 19'h12C01) begin
        errors++;
        $display("FAIL dup_addrs: got %h %h required 12c00 12c01",
                 dut_wr[0].addr, dut_wr[1].addr);
      end
    end
  endtask

  task automatic test_overflow();
    pix_addr_t base;
    base = pix_addr_t'($urandom_range(0, 300000));
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if (i < 10) cycle(1, base + pix_addr_t'(i), pix_color_t'($urandom), 0, 0);
      else        cycle(0, '0, '0, 0, 0);
      checks++;
      if ({mem_wen, stop, frame_done, overflow} !== {m_busy, m_stop, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL ovf_cycle %0d: wen/stop/fd/ovf=%b required %b", i,
                 {mem_wen, stop, frame_done, overflow}, {m_busy, m_stop, m_fd, m_ovf});
      end
    end
    checks++;
    if ({stop, overflow} !== 2'b11) begin
      errors++;
      $display("FAIL ovf_full: stop/ovf=%b required 11", {stop, overflow});
    end
    for (int i = 0; i < 16; i++) begin
      cycle(0, '0, '0, 0, 1);
      checks++;
      if ({mem_wen, stop, overflow} !== {m_busy, m_stop, m_ovf}) begin
        errors++;
        $display("FAIL ovf_drain %0d: wen/stop/ovf=%b required %b", i,
                 {mem_wen, stop, overflow}, {m_busy, m_stop, m_ovf});
      end
      if (m_busy) begin
        checks++;
        if ({mem_addr, mem_data} !== m_head) begin
          errors++;
          $display("FAIL ovf_head %0d: got %h required %h", i, {mem_addr, mem_data}, m_head);
        end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL ovf_sticky: got %b required 1", overflow);
    end
    checks++;
    if (dut_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL ovf_count: %0d writes required %0d", dut_wr.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++;
        if (dut_wr[i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL ovf_order %0d: got %h required %h", i, dut_wr[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_frame_done();
    pix_addr_t base;
    base = pix_addr_t'($urandom_range(0, 300000));
    do_reset();
    for (int i = 0; i < 25; i++) begin
      cycle(i < 5, base + pix_addr_t'(2 * i), pix_color_t'($urandom), i == 5, (i % 2) == 0);
      checks++;
      if ({mem_wen, stop, frame_done, overflow} !== {m_busy, m_stop, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL fd_cycle %0d: wen/stop/fd/ovf=%b required %b", i,
                 {mem_wen, stop, frame_done, overflow}, {m_busy, m_stop, m_fd, m_ovf});
      end
    end
    checks++;
    if (fd_count != 1) begin
      errors++;
      $display("FAIL fd_pulses: %0d pulses required 1", fd_count);
    end
    // Acknowledge is taken on edge last_wr_cyc+1; the pulse must be
    // registered on the following edge.
    checks++;
    if (fd_cyc != last_wr_cyc + 2) begin
      errors++;
      $display("FAIL fd_timing: pulse edge %0d required %0d", fd_cyc, last_wr_cyc + 2);
    end
    checks++;
    if (dut_wr.size() != 5) begin
      errors++;
      $display("FAIL fd_writes: %0d writes required 5", dut_wr.size());
    end
  endtask

  task automatic test_reset_midwrite();
    pix_addr_t base;
    base = pix_addr_t'($urandom_range(0, 300000));
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, base + pix_addr_t'(i), pix_color_t'($urandom), 0, 0);
    checks++;
    if (mem_wen !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: wen=%b required 1", mem_wen);
    end
    addr_valid = 0;
    #2;
    n_rst = 0;
    #1;
    checks++;
    if ({mem_wen, stop, overflow, frame_done} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst_async: wen/stop/ovf/fd=%b required 0000",
               {mem_wen, stop, overflow, frame_done});
    end
    @(posedge clk);
    #1;
    n_rst = 1;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      cycle(0, '0, '0, 0, 1);
      checks++;
      if ({mem_wen, stop} !== 2'b00) begin
        errors++;
        $display("FAIL midrst_after %0d: wen/stop=%b required 00", i, {mem_wen, stop});
      end
    end
    checks++;
    if (dut_wr.size() != 0) begin
      errors++;
      $display("FAIL midrst_writes: %0d writes required 0", dut_wr.size());
    end
  endtask

  task automatic test_wrap();
    pix_addr_t base;
    base = pix_addr_t'($urandom_range(0, 300000));
    do_reset();
    for (int i = 0; i < 26; i++) begin
      if (i < 20) cycle(1, base + pix_addr_t'(i), pix_color_t'($urandom), 0, 1);
      else        cycle(0, '0, '0, 0, 1);
      checks++;
      if (stop !== 1'b0 || mem_wen !== m_busy) begin
        errors++;
        $display("FAIL wrap_cycle %0d: stop/wen=%b required 0%b", i, {stop, mem_wen}, m_busy);
      end
    end
    checks++;
    if (dut_wr.size() != 20) begin
      errors++;
      $display("FAIL wrap_count: %0d writes required 20", dut_wr.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        checks++;
        if (dut_wr[i] !== exp_wr[i] || dut_wr[i].addr !== base + pix_addr_t'(i)) begin
          errors++;
          $display("FAIL wrap_order %0d: got %h required %h", i, dut_wr[i], exp_wr[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    pix_addr_t a;
    int r;
    do_reset();
    for (int i = 0; i < 340; i++) begin
      r = $urandom_range(0, 9);
      if (r < 6)      a = pix_addr_t'($urandom_range(0, 7));
      else if (r < 8) a = pix_addr_t'($urandom_range(0, MAX_ADDR));
      else            a = pix_addr_t'(MAX_ADDR + 1 + $urandom_range(0, 1000));
      if (i < 300)
        cycle($urandom_range(0, 9) < 7, a, pix_color_t'($urandom),
              $urandom_range(0, 29) == 0, $urandom_range(0, 9) < 6);
      else
        cycle(0, '0, '0, i == 300, 1);
      checks++;
      if ({mem_wen, stop, frame_done, overflow} !== {m_busy, m_stop, m_fd, m_ovf}) begin
        errors++;
        $display("FAIL rand_cycle %0d: wen/stop/fd/ovf=%b required %b", i,
                 {mem_wen, stop, frame_done, overflow}, {m_busy, m_stop, m_fd, m_ovf});
      end
      if (m_busy) begin
        checks++;
        if ({mem_addr, mem_data} !== m_head) begin
          errors++;
          $display("FAIL rand_head %0d: got %h required %h", i, {mem_addr, mem_data}, m_head);
        end
      end
    end
    checks++;
    if (dut_wr.size() != exp_wr.size()) begin
      errors++;
      $display("FAIL rand_count: %0d writes required %0d", dut_wr.size(), exp_wr.size());
    end else begin
      for (int i = 0; i < exp_wr.size(); i++) begin
        checks++;
        if (dut_wr[i] !== exp_wr[i]) begin
          errors++;
          $display("FAIL rand_order %0d: got %h required %h", i, dut_wr[i], exp_wr[i]);
        end
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic();
    test_dup_clip();
    test_overflow();
    test_frame_done();
    test_reset_midwrite();
    test_wrap();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
